// File: rtl/big_ram_arbiter.sv
// Round-robin arbiter sharing the tile RAM read/write port among NCLI requesters,
// with a per-client lock that holds the grant across read-modify-write sequences.
module big_ram_arbiter #(
    parameter int unsigned NCLI      = 3,
    parameter int unsigned AW        = 11,
    parameter int unsigned DW        = 6,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCLI-1:0]      req,
    input  logic [NCLI-1:0]      lock,
    input  logic [NCLI-1:0]      we,
    input  logic [NCLI*AW-1:0]   addr,
    input  logic [NCLI*DW-1:0]   wdata,
    output logic [NCLI-1:0]      gnt,
    output logic                 rvalid,
    output logic [2:0]           rid,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        BIG_RD_ADDR,
    output logic [AW-1:0]        BIG_WR_ADDR,
    output logic                 BIG_WR_EN,
    output logic [DW-1:0]        BIG_WR_DATA,
    input  logic [DW-1:0]        BIG_RD_DATA
);

    localparam int unsigned IW = 3;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BCNT_MAX  = '1;
    localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [NCLI-1:0] gnt_q, gnt_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            wr_en_q, wr_en_d;
    logic            p1_valid_q, p1_valid_d;
    logic [IW-1:0]   p1_id_q, p1_id_d;
    logic            p2_valid_q, p2_valid_d;
    logic [IW-1:0]   p2_id_q, p2_id_d;
    logic            rvalid_q, rvalid_d;
    logic [IW-1:0]   rid_q, rid_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            own_req, own_lock, own_we;
    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_wdata;
    logic [IW-1:0]   pick, pick_lo, pick_hi;
    logic            pick_hi_v;
    logic [BW-1:0]   bcnt_inc;
    logic            release_own;

    // Owner's request view and round-robin pick (lowest at/above rr_ptr, else lowest overall)
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        pick_lo   = '0;
        pick_hi   = '0;
        pick_hi_v = 1'b0;
        for (int i = 0; i < NCLI; i++) begin
            if (owner_q == IW'(i)) begin
                own_req   = req[i];
                own_lock  = lock[i];
                own_we    = we[i];
                own_addr  = addr[i*AW +: AW];
                own_wdata = wdata[i*DW +: DW];
            end
        end
        for (int i = NCLI - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_lo = IW'(i);
                if (IW'(i) >= rr_ptr_q) begin
                    pick_hi   = IW'(i);
                    pick_hi_v = 1'b1;
                end
            end
        end
        pick = pick_hi_v ? pick_hi : pick_lo;
    end

    // Next-state: arbitration FSM, write/read issue, read-return pipeline
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        bcnt_d      = bcnt_q;
        gnt_d       = gnt_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        p1_valid_d  = 1'b0;
        p1_id_d     = p1_id_q;
        p2_valid_d  = p1_valid_q;
        p2_id_d     = p1_id_q;
        rvalid_d    = p2_valid_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        bcnt_inc    = (bcnt_q == BCNT_MAX) ? bcnt_q : bcnt_q + BW'(1);
        release_own = 1'b0;

        if (p2_valid_q) begin
            rid_d   = p2_id_q;
            rdata_d = BIG_RD_DATA;
        end

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWN;
                    owner_d = pick;
                    bcnt_d  = '0;
                    for (int i = 0; i < NCLI; i++) begin
                        gnt_d[i] = (pick == IW'(i));
                    end
                end
            end
            OWN: begin
                if (own_req) begin
                    bcnt_d = bcnt_inc;
                    if (own_we) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = own_addr;
                        wr_data_d = own_wdata;
                    end else begin
                        rd_addr_d  = own_addr;
                        p1_valid_d = 1'b1;
                        p1_id_d    = owner_q;
                    end
                end
                // Lock overrides both the idle release and the fairness cap
                release_own = !own_lock && (!own_req || (bcnt_inc >= BURST_LIM));
                if (release_own) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    bcnt_d   = '0;
                    rr_ptr_d = (owner_q == IW'(NCLI - 1)) ? '0 : owner_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            bcnt_q     <= '0;
            gnt_q      <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            p1_valid_q <= 1'b0;
            p1_id_q    <= '0;
            p2_valid_q <= 1'b0;
            p2_id_q    <= '0;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            bcnt_q     <= bcnt_d;
            gnt_q      <= gnt_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            p1_valid_q <= p1_valid_d;
            p1_id_q    <= p1_id_d;
            p2_valid_q <= p2_valid_d;
            p2_id_q    <= p2_id_d;
            rvalid_q   <= rvalid_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign gnt         = gnt_q;
    assign rvalid      = rvalid_q;
    assign rid         = rid_q;
    assign rdata       = rdata_q;
    assign BIG_RD_ADDR = rd_addr_q;
    assign BIG_WR_ADDR = wr_addr_q;
    assign BIG_WR_EN   = wr_en_q;
    assign BIG_WR_DATA = wr_data_q;

endmodule

// File: tb/tb_big_ram_arbiter.sv
// Bench for big_ram_arbiter: directed scenarios plus random traffic, with a
// transaction-level model of arbitration, the 1-cycle RAM and the read return path.
module tb_big_ram_arbiter;

    localparam int N  = 3;
    localparam int AW = 11;
    localparam int DW = 6;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic            rvalid;
    logic [2:0]      rid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   big_rd_addr, big_wr_addr;
    logic            big_wr_en;
    logic [DW-1:0]   big_wr_data, ram_q;

    logic [DW-1:0]   ram [0:2047];
    logic            pl_en;
    logic [AW-1:0]   pl_addr;
    logic [DW-1:0]   pl_data;

    always #5 clk = ~clk;

    big_ram_arbiter #(.NCLI(N), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .BIG_RD_ADDR(big_rd_addr), .BIG_WR_ADDR(big_wr_addr), .BIG_WR_EN(big_wr_en),
        .BIG_WR_DATA(big_wr_data), .BIG_RD_DATA(ram_q)
    );

    // Synchronous RAM, read-before-write; preload port used only while the arbiter is in reset
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (big_wr_en) ram[big_wr_addr] <= big_wr_data;
        ram_q <= ram[big_rd_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int            m_owner, m_ptr, m_cnt;
    logic [DW-1:0] m_mem [0:2047];
    logic          e_wr_en, e_rvalid;
    logic [AW-1:0] e_wr_addr, e_rd_addr;
    logic [DW-1:0] e_wr_data, e_rdata;
    int            e_rid;
    logic          s1_v, s2_v;
    int            s1_id, s2_id;
    logic [DW-1:0] s2_d;
    logic          last_rvalid;
    int            last_rid;
    logic [DW-1:0] last_rdata;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_cnt = 0;
        e_wr_en = 1'b0; e_rvalid = 1'b0; e_wr_addr = '0; e_rd_addr = '0;
        e_wr_data = '0; e_rdata = '0; e_rid = 0;
        s1_v = 1'b0; s2_v = 1'b0; s1_id = 0; s2_id = 0; s2_d = '0;
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare
    task automatic step();
        logic [DW-1:0] rd_val;
        int            o;
        logic          acc;
        int            exp_gnt;
        @(posedge clk);
        rd_val = m_mem[e_rd_addr];
        if (e_wr_en) m_mem[e_wr_addr] = e_wr_data;
        e_rvalid = s2_v;
        if (s2_v) begin
            e_rid   = s2_id;
            e_rdata = s2_d;
        end
        s2_v = s1_v; s2_id = s1_id; s2_d = rd_val;
        e_wr_en = 1'b0; s1_v = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req[c] && m_owner < 0) m_owner = c;
            end
            m_cnt = 0;
        end else begin
            o   = m_owner;
            acc = req[o];
            if (acc) begin
                m_cnt++;
                if (we[o]) begin
                    e_wr_en   = 1'b1;
                    e_wr_addr = addr[o*AW +: AW];
                    e_wr_data = wdata[o*DW +: DW];
                end else begin
                    s1_v      = 1'b1;
                    s1_id     = o;
                    e_rd_addr = addr[o*AW +: AW];
                end
            end
            if (!lock[o] && (!acc || m_cnt >= MB)) begin
                m_owner = -1;
                m_ptr   = (o + 1) % N;
                m_cnt   = 0;
            end
        end
        #1;
        exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("wr_en", 32'(big_wr_en), 32'(e_wr_en));
        check("wr_addr", 32'(big_wr_addr), 32'(e_wr_addr));
        check("wr_data", 32'(big_wr_data), 32'(e_wr_data));
        check("rd_addr", 32'(big_rd_addr), 32'(e_rd_addr));
        check("rvalid", 32'(rvalid), 32'(e_rvalid));
        if (e_rvalid) begin
            check("rid", 32'(rid), 32'(e_rid));
            check("rdata", 32'(rdata), 32'(e_rdata));
        end
        last_rvalid = rvalid;
        last_rid    = int'(rid);
        last_rdata  = rdata;
    endtask

    task automatic idle(input int n);
        req = '0; lock = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_bus();
        we = N'($urandom);
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = AW'($urandom_range(0, 255));
            wdata[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        addr[c*AW +: AW] = a;
    endtask

    initial begin
        int            got_n, first_i, last_i, foreign;
        logic          seen;
        logic [DW-1:0] v;

        rst = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        model_reset();
        #1;
        check("reset_gnt", 32'(gnt), 32'(0));
        check("reset_wr_en", 32'(big_wr_en), 32'(0));
        check("reset_rvalid", 32'(rvalid), 32'(0));
        check("reset_rd_addr", 32'(big_rd_addr), 32'(0));

        // Preload RAM with random contents and the fixed test cells
        pl_en = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            v = DW'($urandom_range(0, 63));
            if (i >= 'h305 && i <= 'h308) v = DW'(i - 'h305 + 1);
            if (i == 'h186) v = DW'(3);
            pl_addr = AW'(i); pl_data = v; m_mem[i] = v;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        @(negedge clk) rst = 1'b1;

        // Round robin, all requesting: MB-access grants, one dead cycle between
        req = 3'b111; lock = '0;
        for (int k = 0; k < 4 * (MB + 1); k++) begin
            rand_bus();
            step();
            check("rr_gnt", 32'(gnt), (k % (MB + 1) == MB) ? 32'(0) : 32'(1 << ((k / (MB + 1)) % N)));
        end
        idle(2);

        // Single client: four reads of 0x305..0x308
        req = 3'b010; we = '0; set_addr(1, 11'h305);
        step();
        check("single_gnt", 32'(gnt), 32'(3'b010));
        got_n = 0; first_i = -1; last_i = -1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) set_addr(1, AW'('h305 + i)); else req = '0;
            step();
            if (last_rvalid) begin
                check("single_rid", 32'(last_rid), 32'(1));
                check("single_rdata", 32'(last_rdata), 32'(got_n + 1));
                if (first_i < 0) first_i = i;
                last_i = i;
                got_n++;
            end
        end
        check("single_count", 32'(got_n), 32'(4));
        check("single_back2back", 32'(last_i - first_i), 32'(3));
        idle(2);

        // Lock: client0 writes 20 times while client2 waits
        req = 3'b001; lock = 3'b001; rand_bus(); we = 3'b001;
        step();
        check("lock_first_gnt", 32'(gnt), 32'(3'b001));
        for (int i = 0; i < 20; i++) begin
            rand_bus(); we = 3'b001; req = 3'b101; lock = 3'b001;
            step();
            check("lock_gnt", 32'(gnt), 32'(3'b001));
            check("lock_wr_en", 32'(big_wr_en), 32'(1));
        end
        req = 3'b100; lock = '0;
        step();
        check("lock_release", 32'(gnt), 32'(0));
        step();
        check("lock_next_gnt", 32'(gnt), 32'(3'b100));
        idle(2);

        // Read-modify-write of 0x186 by client2 under lock
        req = 3'b100; lock = 3'b100; we = '0; set_addr(2, 11'h186);
        step();
        check("rmw_gnt", 32'(gnt), 32'(3'b100));
        rand_bus(); we = 3'b001; set_addr(2, 11'h186); req = 3'b101;
        step();
        req = 3'b001; seen = 1'b0; foreign = 0;
        for (int j = 0; j < 4 && !seen; j++) begin
            step();
            if (big_wr_en) foreign++;
            if (last_rvalid) begin
                seen = 1'b1;
                check("rmw_rdata", 32'(last_rdata), 32'(3));
                check("rmw_rid", 32'(last_rid), 32'(2));
            end
        end
        check("rmw_read_returned", 32'(seen), 32'(1));
        req = 3'b101; we = 3'b101; wdata[2*DW +: DW] = DW'(5);
        step();
        check("rmw_wr_en", 32'(big_wr_en), 32'(1));
        check("rmw_wr_addr", 32'(big_wr_addr), 32'(11'h186));
        check("rmw_no_foreign_write", 32'(foreign), 32'(0));
        lock = '0; req = 3'b001;
        step(); step(); step();
        idle(3);
        check("rmw_ram_cell", 32'(ram[11'h186]), 32'(5));

        // Read in flight across a grant change
        req = 3'b001; we = '0; set_addr(0, 11'h307); set_addr(1, 11'h010);
        step();
        check("flight_gnt0", 32'(gnt), 32'(3'b001));
        req = 3'b011;
        step();
        req = 3'b010;
        step();
        step();
        check("flight_gnt1", 32'(gnt), 32'(3'b010));
        check("flight_rvalid", 32'(rvalid), 32'(1));
        check("flight_rid", 32'(rid), 32'(0));
        check("flight_rdata", 32'(rdata), 32'(3));
        idle(3);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_bus();
            req  = N'($urandom);
            lock = '0;
            for (int c = 0; c < N; c++) lock[c] = ($urandom_range(0, 7) == 0);
            step();
        end
        idle(4);

        // Asynchronous reset in the middle of a write burst
        req = 3'b001; lock = '0; rand_bus(); we = 3'b001;
        step(); step(); step();
        check("pre_reset_wr_en", 32'(big_wr_en), 32'(1));
        #2 rst = 1'b0;
        #1;
        check("async_gnt", 32'(gnt), 32'(0));
        check("async_wr_en", 32'(big_wr_en), 32'(0));
        check("async_rvalid", 32'(rvalid), 32'(0));
        model_reset();
        req = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst = 1'b1;
        req = 3'b111; rand_bus();
        step();
        check("post_reset_gnt", 32'(gnt), 32'(3'b001));
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
